// File: rtl/reg_rd_pkg.sv
// rtl/reg_rd_pkg.sv - shared types and defaults for the read-once register port
package reg_rd_pkg;

    localparam int DEFAULT_NUM_REGS = 4;
    localparam int DEFAULT_DATA_W   = 16;
    localparam int ADDR_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RESP    = 2'd2
    } rd_state_t;

endpackage

// File: rtl/register_read_once_port_if.sv
// rtl/register_read_once_port_if.sv - read request/response bundle (rd_parity present under REG_RD_PARITY_EN)
interface register_read_once_port_if #(
    parameter int DATA_W = 16
);
    logic              rd_req;
    logic [3:0]        rd_addr;
    logic              rd_ready;
    logic              rd_busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_locked;
    logic              rd_err;
`ifdef REG_RD_PARITY_EN
    logic              rd_parity;

    modport master (
        output rd_req, rd_addr, rd_ready,
        input  rd_busy, rd_valid, rd_data, rd_locked, rd_err, rd_parity
    );

    modport slave (
        input  rd_req, rd_addr, rd_ready,
        output rd_busy, rd_valid, rd_data, rd_locked, rd_err, rd_parity
    );
`else
    modport master (
        output rd_req, rd_addr, rd_ready,
        input  rd_busy, rd_valid, rd_data, rd_locked, rd_err
    );

    modport slave (
        input  rd_req, rd_addr, rd_ready,
        output rd_busy, rd_valid, rd_data, rd_locked, rd_err
    );
`endif
endinterface

// File: rtl/reg_rd_parity.sv
// rtl/reg_rd_parity.sv - even parity bit over a lock flag plus data word
module reg_rd_parity #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W:0] bits_in,
    output logic            parity
);

    // Parity bit makes the total count of ones (including itself) even
    assign parity = ^bits_in;

endmodule

// File: rtl/register_read_once_port.sv
// rtl/register_read_once_port.sv - snapshot read port for write-once registers (option: REG_RD_PARITY_EN)
module register_read_once_port
    import reg_rd_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int DATA_W   = DEFAULT_DATA_W
) (
    input  logic                       Clk,
    input  logic                       ip_resetn,
    input  logic [NUM_REGS*DATA_W-1:0] reg_data,
    input  logic [NUM_REGS-1:0]        reg_locked,
    register_read_once_port_if.slave   rd_if
);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              locked_q;
    logic              err_q;

    logic [DATA_W-1:0] sel_data;
    logic              sel_locked;
    logic              sel_err;
    logic              accept;
    logic              resp_valid;

    assign accept     = (state_q == ST_IDLE) && rd_if.rd_req;
    assign resp_valid = (state_q == ST_RESP);

    // State register; reset aborts any transfer in flight
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one capture cycle, then hold the response until accepted
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rd_if.rd_req)   state_d = ST_CAPTURE;
            ST_CAPTURE:                     state_d = ST_RESP;
            ST_RESP:    if (rd_if.rd_ready) state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // Latch the address only when a request is accepted; later requests are dropped
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= rd_if.rd_addr;
        end
    end

    // Register select; an out-of-range index matches nothing and yields zeros
    always_comb begin
        sel_data   = '0;
        sel_locked = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                sel_data   = reg_data[i*DATA_W +: DATA_W];
                sel_locked = reg_locked[i];
            end
        end
        sel_err = ({1'b0, addr_q} >= 5'(NUM_REGS));
    end

    // Snapshot taken in CAPTURE so later register changes cannot disturb the response
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            data_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (state_q == ST_CAPTURE) begin
            data_q   <= sel_data;
            locked_q <= sel_locked;
            err_q    <= sel_err;
        end
    end

    assign rd_if.rd_busy   = (state_q != ST_IDLE);
    assign rd_if.rd_valid  = resp_valid;
    assign rd_if.rd_data   = resp_valid ? data_q : '0;
    assign rd_if.rd_locked = resp_valid & locked_q;
    assign rd_if.rd_err    = resp_valid & err_q;

`ifdef REG_RD_PARITY_EN
    logic parity_d;
    logic parity_q;

    reg_rd_parity #(
        .DATA_W (DATA_W)
    ) u_parity (
        .bits_in ({sel_locked, sel_data}),
        .parity  (parity_d)
    );

    // Parity is captured alongside the data so it always describes the held response
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            parity_q <= 1'b0;
        end else if (state_q == ST_CAPTURE) begin
            parity_q <= parity_d;
        end
    end

    assign rd_if.rd_parity = resp_valid & parity_q;
`endif

endmodule

// File: doc/register_read_once_port.md
REGISTER_READ_ONCE_PORT -- requirements
Module: register_read_once_port

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of write-once registers served (2..16).
REQ-002 SHALL have parameter DATA_W, default 16, register data width.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port ip_resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rd_req  input  1  read request, sampled only in IDLE.
REQ-006 SHALL have port rd_addr  input  4  register index, sampled with rd_req.
REQ-007 SHALL have port reg_data  input  NUM_REGS*DATA_W  flattened register contents, index 0 at LSBs.
REQ-008 SHALL have port reg_locked  input  NUM_REGS  per-register write-once status.
REQ-009 SHALL have port rd_ready  input  1  consumer accepts response.
REQ-010 SHALL have port rd_busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port rd_valid  output  1  response valid.
REQ-012 SHALL have port rd_data  output  DATA_W  response data.
REQ-013 SHALL have port rd_locked  output  1  lock status of the addressed register.
REQ-014 SHALL have port rd_err  output  1  address out of range (rd_addr >= NUM_REGS).

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, RESP.
REQ-016 IDLE: rd_req=1 at edge N SHALL latch rd_addr and enter CAPTURE; rd_req=0 SHALL stay in IDLE.
REQ-017 CAPTURE: edge N+1 SHALL snapshot reg_data[addr] and reg_locked[addr] into holding registers and enter RESP.
REQ-018 RESP: rd_valid SHALL be 1 from edge N+2 (latency 2 cycles request-to-valid).
REQ-019 rd_data, rd_locked, rd_err SHALL stay stable while rd_valid=1 and rd_ready=0.
REQ-020 rd_valid & rd_ready at an edge SHALL return to IDLE, deasserting rd_valid the same edge.
REQ-021 rd_ready asserted in the first RESP cycle SHALL complete the transfer (minimum 3-cycle turnaround).
REQ-022 rd_req outside IDLE SHALL be ignored; no queuing.
REQ-023 Changes to reg_data/reg_locked after the CAPTURE edge SHALL NOT alter the held response.
REQ-024 Out-of-range address SHALL give rd_err=1, rd_data=0, rd_locked=0; FSM timing unchanged.
REQ-025 rd_data/rd_locked/rd_err SHALL read 0 when rd_valid=0.

Reset
REQ-026 ip_resetn=0 SHALL force state IDLE and all outputs 0 immediately, independent of Clk.
REQ-027 Reset during CAPTURE or RESP SHALL abort the transfer; no response issued after release.
REQ-028 First rd_req SHALL be accepted on the first Clk edge with ip_resetn=1.

Configuration
REQ-029 Macro REG_RD_PARITY_EN SHALL, when defined, add output rd_parity (1 bit) = even parity over {rd_locked, rd_data}, registered with the response and 0 when rd_valid=0.
REQ-030 Without REG_RD_PARITY_EN the port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package reg_rd_pkg SHALL hold the FSM state enum, default DATA_W and NUM_REGS constants.
REQ-032 Sub-module reg_rd_parity (combinational parity over DATA_W+1 bits) SHALL be instantiated only under REG_RD_PARITY_EN; FSM and mux stay in the top module.

Verification
REQ-033 Reset then reg_data[1]=16'hA5A4, reg_locked[1]=1, rd_req with addr 1, rd_ready=1 -> rd_valid at cycle+2, rd_data=16'hA5A4, rd_locked=1, rd_err=0, back to IDLE next cycle.
REQ-034 rd_ready held 0 for 5 cycles while reg_data[0] changes 16'h0002->16'hFFFE after CAPTURE -> rd_data stays 16'h0002 all 5 cycles.
REQ-035 rd_addr=4 with NUM_REGS=4 -> rd_err=1, rd_data=16'h0000, rd_locked=0, latency 2.
REQ-036 rd_req pulsed during RESP with addr 2 -> ignored; only one response, no second rd_valid.
REQ-037 ip_resetn low in CAPTURE -> outputs 0 asynchronously, rd_valid never asserts for that request.
REQ-038 With REG_RD_PARITY_EN, rd_data=16'h0001, rd_locked=0 -> rd_parity=1; with rd_locked=1 -> rd_parity=0.
